// File: rtl/uart_lite_pkg.sv
// Shared definitions for the lite UART transmitter: LSR bit layout and TX FSM states.
package uart_lite_pkg;

    localparam int LSR_OE        = 1;
    localparam int LSR_THRE      = 5;
    localparam int LSR_TEMT      = 6;
    // LSR occupies byte lane 5 (bits 47:40) of the 64-bit THR/LSR word
    localparam int LSR_BYTE_LANE = 5;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO. Pointers carry one extra wrap bit so full/empty fall out
// of a simple compare; a push into a full FIFO is taken only alongside a pop.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clka,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; wrap is the natural rollover of the AW+1 bit counters
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty gates every read
    always_ff @(posedge clka) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_lite_tx.sv
// 8N1 UART transmitter behind an SRAM-style slave port. One 64-bit word at
// BASE_ADDR: writes to byte 0 queue a THR byte, reads return a 16550-style LSR.
module uart_lite_tx
    import uart_lite_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR  = 64'h6000_0000,
    parameter int          DIVISOR    = 868,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clka,
    input  logic        rstn,
    input  logic [63:0] addra,
    input  logic [63:0] dina,
    output logic [63:0] douta,
    input  logic        ena,
    input  logic [7:0]  wea,
    output logic        uart_tx
);

    localparam logic [15:0] BAUD_RELOAD = 16'(DIVISOR - 1);

    logic        hit, push, rd, pop;
    logic        full, empty, oe;
    logic [7:0]  fifo_dout, lsr;
    tx_state_t   state, state_n;
    logic [15:0] baud_cnt, baud_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shreg, sh_n;
    logic        tx_n;

    assign hit  = ena && ({addra[63:3], 3'b000} == BASE_ADDR);
    assign push = hit && wea[0];
    assign rd   = hit && (wea == 8'h00);

    uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clka  (clka),
        .rstn  (rstn),
        .push  (push),
        .din   (dina[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    // Live LSR view; a read captures it in the access cycle
    always_comb begin
        lsr           = 8'h00;
        lsr[LSR_OE]   = oe;
        lsr[LSR_THRE] = !full;
        lsr[LSR_TEMT] = empty && (state == TX_IDLE);
    end

    // Read data register and sticky overrun flag (cleared by the read that reports it)
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            douta <= '0;
            oe    <= 1'b0;
        end else begin
            douta <= rd ? (64'(lsr) << (8 * LSR_BYTE_LANE)) : 64'h0;
            if (push && full && !pop) oe <= 1'b1;
            else if (rd)              oe <= 1'b0;
        end
    end

    // Next-state logic: every bit lasts DIVISOR cycles, advancing when the baud counter hits 0
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        sh_n    = shreg;
        tx_n    = uart_tx;
        pop     = 1'b0;
        case (state)
            TX_IDLE: begin
                tx_n = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_n    = fifo_dout;
                    baud_n  = BAUD_RELOAD;
                    bit_n   = 3'd0;
                    tx_n    = 1'b0;
                    state_n = TX_START;
                end
            end
            TX_START: begin
                if (baud_cnt == 16'd0) begin
                    baud_n  = BAUD_RELOAD;
                    tx_n    = shreg[0];
                    state_n = TX_DATA;
                end else begin
                    baud_n = baud_cnt - 16'd1;
                end
            end
            TX_DATA: begin
                if (baud_cnt == 16'd0) begin
                    baud_n = BAUD_RELOAD;
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = TX_STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        sh_n  = {1'b0, shreg[7:1]};
                        tx_n  = shreg[1];
                    end
                end else begin
                    baud_n = baud_cnt - 16'd1;
                end
            end
            TX_STOP: begin
                if (baud_cnt == 16'd0) begin
                    if (!empty) begin
                        // back-to-back: next start bit follows the stop bit directly
                        pop     = 1'b1;
                        sh_n    = fifo_dout;
                        baud_n  = BAUD_RELOAD;
                        bit_n   = 3'd0;
                        tx_n    = 1'b0;
                        state_n = TX_START;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = TX_IDLE;
                    end
                end else begin
                    baud_n = baud_cnt - 16'd1;
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = TX_IDLE;
            end
        endcase
    end

    // Transmitter state; uart_tx comes straight from a flop so the pin never glitches
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shreg    <= sh_n;
            uart_tx  <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_lite_tx.sv
// Scoreboard bench for uart_lite_tx (DIVISOR=4, FIFO_DEPTH=4): stimulus queues
// expected bytes / read words, a serial receiver and a read monitor check them.
module tb_uart_lite_tx;

    localparam logic [63:0] BASE = 64'h6000_0000;

    logic        clka = 1'b0;
    logic        rstn = 1'b0;
    logic [63:0] addra = '0;
    logic [63:0] dina = '0;
    logic [63:0] douta;
    logic        ena = 1'b0;
    logic [7:0]  wea = '0;
    logic        uart_tx;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          rx_en = 1'b1;
    logic [7:0]  exp_bytes[$];
    logic [63:0] exp_rd[$];
    int          start_q[$];

    uart_lite_tx #(.BASE_ADDR(BASE), .DIVISOR(4), .FIFO_DEPTH(4)) dut (
        .clka(clka), .rstn(rstn), .addra(addra), .dina(dina), .douta(douta),
        .ena(ena), .wea(wea), .uart_tx(uart_tx)
    );

    always #5 clka = ~clka;

    initial forever begin
        @(posedge clka);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lsr_word(input logic [7:0] v);
        return {16'h0, v, 40'h0};
    endfunction

    // Called at a negedge; presents one write access and returns at the next negedge
    task automatic wr(input logic [63:0] addr, input logic [7:0] data,
                      input logic [7:0] we, input bit exp_frame);
        addra = addr;
        dina  = {56'hABCDEF01234567, data};
        ena   = 1'b1;
        wea   = we;
        if (exp_frame) exp_bytes.push_back(data);
        @(negedge clka);
        ena = 1'b0;
        wea = 8'h00;
    endtask

    task automatic rd(input logic [63:0] addr, input logic [63:0] exp);
        addra = addr;
        ena   = 1'b1;
        wea   = 8'h00;
        exp_rd.push_back(exp);
        @(negedge clka);
        ena = 1'b0;
    endtask

    // Read monitor: any read access yields douta on the following cycle
    initial forever begin
        @(posedge clka);
        if (ena && wea == 8'h00) begin
            @(negedge clka);
            if (exp_rd.size() == 0) chk("rd_unexpected", douta, 64'hx);
            else chk("douta", douta, exp_rd.pop_front());
        end
    end

    // Serial receiver: samples mid-bit (4 cycles/bit), checks framing and byte
    initial forever begin
        logic [7:0] b;
        @(negedge clka);
        if (rx_en && rstn && uart_tx === 1'b0) begin
            start_q.push_back(cyc);
            repeat (2) @(negedge clka);
            chk("rx_start", {63'h0, uart_tx}, 64'h0);
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clka);
                b[i] = uart_tx;
            end
            repeat (4) @(negedge clka);
            chk("rx_stop", {63'h0, uart_tx}, 64'h1);
            if (exp_bytes.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected_frame: got %h, expected none", b);
            end else begin
                chk("rx_byte", {56'h0, b}, {56'h0, exp_bytes.pop_front()});
            end
            @(negedge clka);
        end
    end

    initial begin
        repeat (20000) @(posedge clka);
        errors++;
        $display("FAIL watchdog: run exceeded 20000 cycles");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int lows;
        repeat (3) @(negedge clka);
        chk("reset_uart_tx", {63'h0, uart_tx}, 64'h1);
        chk("reset_douta", douta, 64'h0);
        rstn = 1'b1;
        @(negedge clka);

        // Read after reset: THRE|TEMT
        rd(BASE, 64'h0000_6000_0000_0000);
        repeat (2) @(negedge clka);

        // Single 0x55 frame, start-bit latency and TEMT timing
        wr(BASE, 8'h55, 8'h01, 1'b1);
        chk("t1_line_before", {63'h0, uart_tx}, 64'h1);
        @(negedge clka);
        chk("t1_start_edge", {63'h0, uart_tx}, 64'h0);
        repeat (39) @(negedge clka);
        rd(BASE, lsr_word(8'h20));
        rd(BASE, lsr_word(8'h60));
        repeat (10) @(negedge clka);

        // Three back-to-back frames with no idle gap
        start_q.delete();
        wr(BASE, 8'h41, 8'h01, 1'b1);
        wr(BASE, 8'h42, 8'hFF, 1'b1);
        wr(BASE, 8'h43, 8'h01, 1'b1);
        repeat (130) @(negedge clka);
        chk("t3_frames", 64'(start_q.size()), 64'd3);
        if (start_q.size() == 3) begin
            chk("t3_gap01", 64'(start_q[1] - start_q[0]), 64'd40);
            chk("t3_gap12", 64'(start_q[2] - start_q[1]), 64'd40);
        end

        // Overflow: 6 writes, 5 accepted, OE reported once
        for (int i = 0; i < 6; i++) wr(BASE, 8'h10 + 8'(i), 8'h01, i < 5);
        rd(BASE, lsr_word(8'h02));
        rd(BASE, lsr_word(8'h00));
        repeat (220) @(negedge clka);
        rd(BASE, lsr_word(8'h60));

        // Non-hit write and wea[0]=0 write: no frame, no side effects
        lows = 0;
        wr(BASE + 64'd8, 8'h99, 8'h01, 1'b0);
        wr(BASE, 8'h77, 8'h02, 1'b0);
        rd(BASE + 64'd8, 64'h0);
        rd(BASE + 64'd4, lsr_word(8'h60));
        for (int i = 0; i < 50; i++) begin
            @(negedge clka);
            if (uart_tx !== 1'b1) lows++;
        end
        chk("t5_line_idle", 64'(lows), 64'd0);

        // Reset during DATA bit 3 of 0xA5
        rx_en = 1'b0;
        wr(BASE, 8'hA5, 8'h01, 1'b0);
        wr(BASE, 8'h5A, 8'h01, 1'b0);
        repeat (17) @(negedge clka);
        chk("t6_bit3", {63'h0, uart_tx}, 64'h0);
        #2 rstn = 1'b0;
        #1 chk("t6_reset_line", {63'h0, uart_tx}, 64'h1);
        repeat (2) @(negedge clka);
        rstn = 1'b1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clka);
            if (uart_tx !== 1'b1) lows++;
        end
        chk("t6_idle_after", 64'(lows), 64'd0);
        rx_en = 1'b1;
        rd(BASE, lsr_word(8'h60));
        repeat (3) @(negedge clka);

        chk("pending_bytes", 64'(exp_bytes.size()), 64'd0);
        chk("pending_reads", 64'(exp_rd.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
